// File: rtl/counter_key_ctrl.sv
// Key front-end for the up/down counter: sync, debounce, run/stop/clear FSM, tick divider.
// Optional: define LONG_PRESS_CLR_EN to make a long run-key hold inject a clear.
module counter_key_ctrl #(
  parameter int DEB_CYCLES  = 20,
  parameter int TICK_DIV    = 50,
  parameter int CLR_HOLD    = 4,
  parameter int LONG_CYCLES = 100
) (
  input  logic clk,
  input  logic clr,
  input  logic key_run_n,
  input  logic key_clr_n,
  output logic stop_n,
  output logic clr_n,
  output logic tick,
  output logic slow_clk
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CLR
  } state_t;

  // index 0 = run key, index 1 = clear key
  logic [1:0]    r_sync0;
  logic [1:0]    r_sync1;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_d;
  logic [DW-1:0] r_cnt [2];
  logic [1:0]    w_press;
  logic          w_clr_ev;

  state_t        r_state;
  logic [HW-1:0] r_hold;
  logic          r_stop_n;
  logic          r_clr_n;
  logic [TW-1:0] r_div;
  logic          r_tick;
  logic          r_slow;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync0 <= 2'b11;
      r_sync1 <= 2'b11;
    end else begin
      r_sync0 <= {key_clr_n, key_run_n};
      r_sync1 <= r_sync0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_deb   <= 2'b11;
      r_deb_d <= 2'b11;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int k = 0; k < 2; k++) begin
        if (r_sync1[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == DW'(DEB_CYCLES - 1)) begin
          r_deb[k] <= r_sync1[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + DW'(1);
        end
      end
    end
  end

  assign w_press = r_deb_d & ~r_deb;

`ifdef LONG_PRESS_CLR_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);

  logic [LW-1:0] r_long;
  logic          r_long_press;

  // saturates at LONG_CYCLES so one hold fires once
  always_ff @(posedge clk) begin
    if (clr) begin
      r_long       <= '0;
      r_long_press <= 1'b0;
    end else begin
      r_long_press <= !r_deb[0] &&
        (r_long == LW'(LONG_CYCLES - 1));
      if (r_deb[0])
        r_long <= '0;
      else if (r_long != LW'(LONG_CYCLES))
        r_long <= r_long + LW'(1);
    end
  end

  assign w_clr_ev = w_press[1] | r_long_press;
`else
  logic w_unused_long;
  assign w_unused_long = (LONG_CYCLES > 0);
  assign w_clr_ev = w_press[1];
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= S_CLR;
      r_hold   <= HW'(CLR_HOLD - 1);
      r_stop_n <= 1'b0;
      r_clr_n  <= 1'b0;
    end else if (w_clr_ev) begin
      r_state  <= S_CLR;
      r_hold   <= HW'(CLR_HOLD - 1);
      r_stop_n <= 1'b0;
      r_clr_n  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_press[0]) begin
            r_state  <= S_RUN;
            r_stop_n <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_press[0]) begin
            r_state  <= S_IDLE;
            r_stop_n <= 1'b0;
          end
        end
        S_CLR: begin
          if (r_hold == '0) begin
            r_state <= S_IDLE;
            r_clr_n <= 1'b1;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end
        default: begin
          r_state  <= S_CLR;
          r_hold   <= HW'(CLR_HOLD - 1);
          r_stop_n <= 1'b0;
          r_clr_n  <= 1'b0;
        end
      endcase
    end
  end

  // divider keeps wrapping on a leaving edge; only the tick is dropped
  always_ff @(posedge clk) begin
    if (clr || w_clr_ev || r_state == S_CLR) begin
      r_div  <= '0;
      r_slow <= 1'b0;
      r_tick <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_tick <= 1'b0;
      if (r_div == TW'(TICK_DIV - 1)) begin
        r_div <= '0;
        if (!w_press[0]) begin
          r_tick <= 1'b1;
          r_slow <= ~r_slow;
        end
      end else begin
        r_div <= r_div + TW'(1);
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign stop_n   = r_stop_n;
  assign clr_n    = r_clr_n;
  assign tick     = r_tick;
  assign slow_clk = r_slow;

endmodule

// File: tb/tb_counter_key_ctrl.sv
// Bench for counter_key_ctrl: directed key scenarios plus random key
// traffic, all checked against a cycle reference model.
module tb_counter_key_ctrl;

  localparam int DEB = 20;
  localparam int TD  = 50;
  localparam int CH  = 4;
  localparam int LC  = 100;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_CLR  = 2;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic key_run_n = 1'b1;
  logic key_clr_n = 1'b1;
  logic stop_n;
  logic clr_n;
  logic tick;
  logic slow_clk;

  always #5 clk = ~clk;

  counter_key_ctrl #(
    .DEB_CYCLES (DEB),
    .TICK_DIV   (TD),
    .CLR_HOLD   (CH),
    .LONG_CYCLES(LC)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .key_run_n(key_run_n),
    .key_clr_n(key_clr_n),
    .stop_n   (stop_n),
    .clr_n    (clr_n),
    .tick     (tick),
    .slow_clk (slow_clk)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int m_s1[2], m_s2[2], m_deb[2], m_pd[2], m_cnt[2];
  int m_mode, m_hold, m_ph, m_slow, m_tick;
  int m_low, m_inj;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1; m_s2[k] = 1; m_deb[k] = 1;
      m_pd[k] = 1; m_cnt[k] = 0;
    end
    m_mode = M_CLR; m_hold = CH - 1;
    m_ph = 0; m_slow = 0; m_tick = 0;
    m_low = 0; m_inj = 0;
  endtask

  task automatic model_step();
    int rp, cp, old, raw[2];
    if (clr) begin
      model_reset();
      return;
    end
    raw[0] = int'(key_run_n);
    raw[1] = int'(key_clr_n);
    rp = (m_pd[0] == 1 && m_deb[0] == 0) ? 1 : 0;
    cp = ((m_pd[1] == 1 && m_deb[1] == 0) || m_inj == 1) ? 1 : 0;
    old = m_mode;
`ifdef LONG_PRESS_CLR_EN
    m_inj = (m_deb[0] == 0 && m_low == LC - 1) ? 1 : 0;
    if (m_deb[0] == 1) m_low = 0;
    else if (m_low < LC) m_low++;
`endif
    if (cp == 1) begin
      m_mode = M_CLR; m_hold = CH - 1;
    end else if (old == M_RUN && rp == 1) m_mode = M_IDLE;
    else if (old == M_IDLE && rp == 1) m_mode = M_RUN;
    else if (old == M_CLR) begin
      if (m_hold == 0) m_mode = M_IDLE;
      else m_hold--;
    end
    if (cp == 1 || old == M_CLR) begin
      m_ph = 0; m_slow = 0; m_tick = 0;
    end else if (old == M_RUN) begin
      m_ph++;
      m_tick = (m_ph % TD == 0 && rp == 0) ? 1 : 0;
      if (m_tick == 1) m_slow = 1 - m_slow;
    end else m_tick = 0;
    for (int k = 0; k < 2; k++) begin
      m_pd[k] = m_deb[k];
      if (m_s2[k] == m_deb[k]) m_cnt[k] = 0;
      else if (m_cnt[k] == DEB - 1) begin
        m_deb[k] = m_s2[k]; m_cnt[k] = 0;
      end else m_cnt[k]++;
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      check("stop_n", int'(stop_n), (m_mode == M_RUN) ? 1 : 0);
      check("clr_n", int'(clr_n), (m_mode != M_CLR) ? 1 : 0);
      check("tick", int'(tick), m_tick);
      check("slow_clk", int'(slow_clk), m_slow);
    end
  endtask

  task automatic wait_stop(input int lvl, output int n);
    n = 0;
    while (int'(stop_n) != lvl && n < 100) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (!tick && n < 200) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    int n, lowc, tk, hi, first, last, fc;
    model_reset();

    clr = 1'b1;
    cyc(3);
    lowc = clr_n ? 0 : 1;
    clr = 1'b0;
    tk = 0; hi = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      lowc += clr_n ? 0 : 1;
      tk += tick ? 1 : 0;
      hi += stop_n ? 1 : 0;
    end
    check("rst_clr_low", lowc, 4);
    check("rst_ticks", tk, 0);
    check("rst_stop", hi, 0);

    for (int i = 0; i < 12; i++) begin
      key_run_n = ~key_run_n;
      cyc(5);
    end
    check("bounce_stop", int'(stop_n), 0);
    key_run_n = 1'b0;
    wait_stop(1, n);
    check("run_latency", n, DEB + 3);

    tk = 0; first = -1; last = -1;
    for (int i = 1; i <= 200; i++) begin
      if (i == 30) key_run_n = 1'b1;
      if (i == 40) key_run_n = 1'b0;
      if (i == 120) key_run_n = 1'b1;
      cyc(1);
      if (tick) begin
        tk++;
        check("slow_at_tick", int'(slow_clk), tk % 2);
        if (first < 0) first = i;
        else check("tick_gap", i - last, TD);
        last = i;
      end
    end
    check("first_tick", first, TD);
    check("tick_count", tk, 4);
    check("glitch_run", int'(stop_n), 1);

    cyc(7);
    key_run_n = 1'b0;
    wait_stop(0, n);
    check("stop_latency", n, DEB + 3);
    key_run_n = 1'b1;
    tk = 0;
    for (int i = 0; i < 500; i++) begin
      cyc(1);
      tk += tick ? 1 : 0;
    end
    check("idle_ticks", tk, 0);
    key_run_n = 1'b0;
    wait_stop(1, n);
    check("resume_latency", n, DEB + 3);
    wait_tick(n);
    check("resume_tick", n, 20);
    key_run_n = 1'b1;
    cyc(30);

    key_run_n = 1'b0;
    wait_stop(0, n);
    key_run_n = 1'b1;
    cyc(30);
    key_run_n = 1'b0;
    key_clr_n = 1'b0;
    n = 0;
    while (clr_n && n < 100) begin
      cyc(1);
      n++;
    end
    check("clr_latency", n, DEB + 3);
    lowc = clr_n ? 0 : 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      lowc += clr_n ? 0 : 1;
    end
    check("clr_hold", lowc, CH);
    check("clr_stop", int'(stop_n), 0);
    check("clr_slow", int'(slow_clk), 0);
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    cyc(30);
    check("run_discard", int'(stop_n), 0);
    key_run_n = 1'b0;
    wait_stop(1, n);
    wait_tick(n);
    check("post_clr_tick", n, TD);
    key_run_n = 1'b1;
    cyc(30);
    key_run_n = 1'b0;
    wait_stop(0, n);
    key_run_n = 1'b1;
    cyc(30);

    key_run_n = 1'b0;
    wait_stop(1, n);
    check("long_rise", n, DEB + 3);
    fc = -1; lowc = 0;
    for (int i = 1; i <= 250; i++) begin
      cyc(1);
      if (!clr_n) begin
        lowc++;
        if (fc < 0) fc = i;
      end
    end
`ifdef LONG_PRESS_CLR_EN
    check("long_clr_at", fc, LC);
    check("long_clr_len", lowc, CH);
    check("long_end", int'(stop_n), 0);
`else
    check("long_no_clr", lowc, 0);
    check("long_end", int'(stop_n), 1);
`endif
    key_run_n = 1'b1;
    cyc(30);

    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        clr = 1'b1;
        cyc(2);
        clr = 1'b0;
      end
      key_run_n = 1'($urandom_range(0, 1));
      key_clr_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      cyc($urandom_range(1, 45));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
